i_mem_loader: RTL

Writer-side counterpart of the instruction ROM. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into a writable instruction memory starting at byte address 0. While a load is in progress it holds the core in reset. At the end of the load it reports either done or error.

---
 rtl/i_mem_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/i_mem_loader.sv
// Byte-stream instruction loader: assembles little-endian words and writes them into the writable instruction memory.
// Optional macro I_MEM_LOADER_CSUM_EN adds a trailing XOR checksum byte to every frame.
module i_mem_loader #(
    parameter int D_WIDTH     = 32,
    parameter int A_WIDTH     = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               we,
    output logic [A_WIDTH-1:0] wa,
    output logic [D_WIDTH-1:0] wd,
    output logic               busy,
    output logic               core_hold,
    output logic               done,
    output logic               err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, FIN, ERR, CSUM
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [15:0]        len;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         byte_idx;
    logic [D_WIDTH-1:0] asm_word;
`ifdef I_MEM_LOADER_CSUM_EN
    logic [7:0]         csum;
`endif

    logic        hs;
    logic [15:0] len_in;

    assign hs        = s_valid & s_ready;
    assign len_in    = {s_data, len_lo};
    assign core_hold = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            we       <= 1'b0;
            wa       <= '0;
            wd       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            len_lo   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
`ifdef I_MEM_LOADER_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            // NOTE: we defaults low every cycle; only the DATA->WRITE transition raises it, giving a one-cycle pulse.
            we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        s_ready  <= 1'b1;
                        word_idx <= '0;
                        byte_idx <= '0;
`ifdef I_MEM_LOADER_CSUM_EN
                        csum     <= '0;
`endif
                        state    <= LEN0;
                    end
                end
                LEN0: begin
                    if (hs) begin
                        len_lo <= s_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (hs) begin
                        len <= len_in;
                        if (len_in == 16'd0) begin
`ifdef I_MEM_LOADER_CSUM_EN
                            state   <= CSUM;
`else
                            s_ready <= 1'b0;
                            state   <= FIN;
`endif
                        end else if (len_in > 16'(DEPTH_WORDS)) begin
                            s_ready <= 1'b0;
                            state   <= ERR;
                        end else begin
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (hs) begin
`ifdef I_MEM_LOADER_CSUM_EN
                        csum <= csum ^ s_data;
`endif
                        if (byte_idx == 2'd3) begin
                            we       <= 1'b1;
                            wa       <= A_WIDTH'({word_idx, 2'b00});
                            wd       <= {s_data, asm_word[23:0]};
                            s_ready  <= 1'b0;
                            byte_idx <= '0;
                            state    <= WRITE;
                        end else begin
                            asm_word[8*byte_idx +: 8] <= s_data;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (16'(word_idx) + 16'd1 == len) begin
`ifdef I_MEM_LOADER_CSUM_EN
                        s_ready <= 1'b1;
                        state   <= CSUM;
`else
                        state   <= FIN;
`endif
                    end else begin
                        s_ready <= 1'b1;
                        state   <= DATA;
                    end
                end
`ifdef I_MEM_LOADER_CSUM_EN
                CSUM: begin
                    if (hs) begin
                        s_ready <= 1'b0;
                        state   <= (s_data == csum) ? FIN : ERR;
                    end
                end
`else
                CSUM: state <= IDLE;
`endif
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
